// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage CPU: opcodes, hazard FSM
// state encoding and exception codes.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_DIV  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_OVERFLOW = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL_MD = 2'd1,
    ST_HALT     = 2'd2,
    ST_EXCEPT   = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter that times the mul/div stall; flags when it reaches one.
module stall_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         cnt_is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en) begin
      cnt <= cnt - W'(1);
    end
  end

  assign cnt_is_one = (cnt == W'(1));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: combinational detection plus a small FSM
// for mul/div stalls, HALT and the overflow trap (HAZARD_OVERFLOW_TRAP_EN).
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [3:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic       ex_muldiv,
  input  logic       ex_overflow,
  output logic       pc_stop,
  output logic       pc_mux,
  output logic       if_id_hold,
  output logic       if_id_flush,
  output logic       id_ex_hold,
  output logic       id_ex_flush,
  output logic       ex_flush,
  output logic       ex_mem_flush,
  output logic       halted,
  output logic       exception,
  output logic [1:0] exception_code,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES);

  hazard_state_t state_q, state_d;
  logic          md_done_q;
  logic          cnt_load, cnt_en, cnt_is_one;
  logic          load_use, overflow_trap;

`ifdef HAZARD_OVERFLOW_TRAP_EN
  assign overflow_trap = ex_overflow;
`else
  logic overflow_unused;
  assign overflow_unused = ex_overflow;
  assign overflow_trap   = 1'b0;
`endif

  assign load_use = ex_mem_read && (ex_rd != 4'd0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  stall_counter #(.W(CNT_W)) u_stall_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .value      (CNT_W'(MULDIV_CYCLES - 1)),
    .en         (cnt_en),
    .cnt_is_one (cnt_is_one)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Guards the completing mul/div for the one cycle it is still in EX.
      md_done_q <= (state_q == ST_STALL_MD) && cnt_is_one;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    pc_stop        = 1'b0;
    pc_mux         = 1'b0;
    if_id_hold     = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_hold     = 1'b0;
    id_ex_flush    = 1'b0;
    ex_flush       = 1'b0;
    ex_mem_flush   = 1'b0;
    halted         = 1'b0;
    exception      = 1'b0;
    exception_code = EXC_NONE;

    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (overflow_trap) begin
            ex_flush    = 1'b1;
            id_ex_flush = 1'b1;
            if_id_flush = 1'b1;
            pc_stop     = 1'b1;
            state_d     = ST_EXCEPT;
          end else if (ex_redirect) begin
            pc_mux      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_muldiv && !md_done_q) begin
            pc_stop      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_load     = 1'b1;
            state_d      = ST_STALL_MD;
          end else if (load_use) begin
            pc_stop     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end else if (id_opcode == OP_HALT) begin
            pc_stop    = 1'b1;
            if_id_hold = 1'b1;
            state_d    = ST_HALT;
          end
        end
        ST_STALL_MD: begin
          pc_stop      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_hold   = 1'b1;
          ex_mem_flush = 1'b1;
          cnt_en       = 1'b1;
          if (cnt_is_one) begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          halted      = 1'b1;
          pc_stop     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end
        ST_EXCEPT: begin
`ifdef HAZARD_OVERFLOW_TRAP_EN
          exception      = 1'b1;
          exception_code = EXC_OVERFLOW;
          pc_stop        = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_flush    = 1'b1;
`else
          state_d = ST_RUN;
`endif
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: per-cycle behavioural model scoreboard plus
// hand-computed literal expectations for each scenario.
module tb_hazard_unit;

  localparam int MDC = 4;
`ifdef HAZARD_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk, rst;
  logic [3:0] id_opcode, id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_mem_read, ex_redirect, ex_muldiv, ex_overflow;
  logic       pc_stop, pc_mux, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic       ex_flush, ex_mem_flush, halted, exception;
  logic [1:0] exception_code, state_dbg;

  int checks = 0;
  int errors = 0;
  bit done = 0;
  logic [11:0] exp_q[$];

  hazard_unit #(.MULDIV_CYCLES(MDC)) dut (
    .clock(clk), .reset(rst),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_muldiv(ex_muldiv), .ex_overflow(ex_overflow),
    .pc_stop(pc_stop), .pc_mux(pc_mux), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_flush(ex_flush),
    .ex_mem_flush(ex_mem_flush), .halted(halted), .exception(exception),
    .exception_code(exception_code), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [11:0] dut_vec();
    return {pc_stop, pc_mux, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
            ex_flush, ex_mem_flush, halted, exception, exception_code};
  endfunction

  // ---------------- behavioural model ----------------
  bit m_halted, m_trapped, m_guard;
  int m_owed;                      // mul/div stall cycles still owed after entry
  bit n_halted, n_trapped, n_guard;
  int n_owed;

  always @(negedge clk) begin
    bit s_pc, s_mux, s_ifh, s_iff, s_idh, s_idf, s_exf, s_emf, s_hl, s_exc;
    bit lu;
    {s_pc, s_mux, s_ifh, s_iff, s_idh, s_idf, s_exf, s_emf, s_hl, s_exc} = '0;
    n_halted = m_halted; n_trapped = m_trapped; n_owed = m_owed; n_guard = 1'b0;
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    if (rst) begin
    end else if (m_halted) begin
      s_hl = 1; s_pc = 1; s_ifh = 1; s_idf = 1;
    end else if (m_trapped) begin
      s_exc = 1; s_pc = 1; s_iff = 1; s_idf = 1;
    end else if (m_owed > 0) begin
      s_pc = 1; s_ifh = 1; s_idh = 1; s_emf = 1;
      n_owed = m_owed - 1;
      n_guard = (n_owed == 0);
    end else if (TRAP && ex_overflow) begin
      s_exf = 1; s_idf = 1; s_iff = 1; s_pc = 1; n_trapped = 1;
    end else if (ex_redirect) begin
      s_mux = 1; s_iff = 1; s_idf = 1;
    end else if (ex_muldiv && !m_guard) begin
      s_pc = 1; s_ifh = 1; s_idh = 1; s_emf = 1; n_owed = MDC - 1;
    end else if (lu) begin
      s_pc = 1; s_ifh = 1; s_idf = 1;
    end else if (id_opcode == 4'hF) begin
      s_pc = 1; s_ifh = 1; n_halted = 1;
    end
    exp_q.push_back({s_pc, s_mux, s_ifh, s_iff, s_idh, s_idf, s_exf, s_emf, s_hl, s_exc,
                     s_exc ? 2'b01 : 2'b00});
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halted <= 0; m_trapped <= 0; m_guard <= 0; m_owed <= 0;
    end else begin
      m_halted <= n_halted; m_trapped <= n_trapped; m_guard <= n_guard; m_owed <= n_owed;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [11:0] e, a;
    #1;
    if (!done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_model t=%0t actual=%03h required=%03h", $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_opcode = 4'h0; id_rs1 = 4'd1; id_rs2 = 4'd2; id_uses_rs2 = 0; ex_rd = 4'd0;
    ex_mem_read = 0; ex_redirect = 0; ex_muldiv = 0; ex_overflow = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #2;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; idle();
    ex_redirect = 1; id_opcode = 4'hF; ex_muldiv = 1;
    probe();
    check("reset_outputs_zero", dut_vec(), 12'h000);
    step(); step(); rst = 0; idle();

    // Load-use on rs1
    ex_mem_read = 1; ex_rd = 4'd3; id_rs1 = 4'd3;
    probe();
    check("lu_stall", {pc_stop, if_id_hold, id_ex_flush}, 3'b111);
    check("lu_no_hold_ex", {id_ex_hold, pc_mux}, 2'b00);
    step(); idle();
    probe();
    check("lu_one_cycle", pc_stop, 1'b0);
    // Load-use on rs2 only when used
    step(); ex_mem_read = 1; ex_rd = 4'd7; id_rs1 = 4'd5; id_rs2 = 4'd7; id_uses_rs2 = 1;
    probe();
    check("lu_rs2", pc_stop, 1'b1);
    step(); id_uses_rs2 = 0;
    probe();
    check("lu_rs2_unused", pc_stop, 1'b0);
    // ex_rd = 0 never hazards
    step(); ex_rd = 4'd0; id_rs1 = 4'd0;
    probe();
    check("lu_rd_zero", {pc_stop, id_ex_flush}, 2'b00);
    step(); idle();

    // Mul/div held for 5 cycles: stall cycles 1-4, free in cycle 5
    ex_muldiv = 1;
    for (int i = 1; i <= 5; i++) begin
      probe();
      check($sformatf("md_cycle%0d", i), {pc_stop, id_ex_hold, ex_mem_flush},
            (i <= 4) ? 3'b111 : 3'b000);
      step();
    end
    idle();

    // Redirect beats load-use and HALT
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 4'd3; id_rs1 = 4'd3; id_opcode = 4'hF;
    probe();
    check("redir_flush", {pc_mux, if_id_flush, id_ex_flush, pc_stop}, 4'b1110);
    step(); idle();
    probe();
    check("redir_no_halt", {halted, pc_stop}, 2'b00);

    // Reset mid-STALL_MD with cnt=2
    step(); ex_muldiv = 1;
    step(); ex_muldiv = 0;
    step();
    probe();
    check("md_before_reset", pc_stop, 1'b1);
    rst = 1; #1;
    check("reset_mid_md", dut_vec(), 12'h000);
    step(); step(); rst = 0;
    probe();
    check("after_reset_run", {pc_stop, id_ex_hold}, 2'b00);

    // HALT, then all inputs ignored for 20 cycles
    step(); id_opcode = 4'hF;
    probe();
    check("halt_entry", {pc_stop, if_id_hold, halted}, 3'b110);
    step(); idle();
    for (int i = 0; i < 20; i++) begin
      ex_redirect = 1'($urandom_range(0, 1));
      ex_muldiv   = 1'($urandom_range(0, 1));
      ex_overflow = 1'($urandom_range(0, 1));
      probe();
      check($sformatf("halt_hold%0d", i), {halted, pc_stop, pc_mux, ex_flush}, 4'b1100);
      step();
    end
    idle(); rst = 1;
    probe();
    check("halt_reset", halted, 1'b0);
    step(); rst = 0;

    // Overflow trap
    step(); ex_overflow = 1;
    probe();
    check("ovf_ex_flush", {ex_flush, pc_stop}, {TRAP, TRAP});
    step(); idle();
    probe();
    check("ovf_exception", {exception, exception_code}, {TRAP, 1'b0, TRAP});
    step();
    probe();
    check("ovf_sticky", exception, TRAP);

    step(); done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 16-bit five-stage CPU. It fills the hazard/control slot of the top level and drives the PC stop and select controls and the hold and flush controls of the IF/ID, ID/EX and EX/MEM buffers. Stall requests come from load-use dependencies, multi-cycle mul/div, taken branches/jumps, HALT and ALU overflow. Detection is combinational; multi-cycle behaviour is held in a small registered FSM.

## Interface
- MULDIV_CYCLES, 4, total stall cycles per mul/div instruction in EX (must be ≥2)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock domain only
- id_opcode  input  4  opcode of the instruction in ID
- id_rs1 / id_rs2  input  4 each  source register fields in ID
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_rd  input  4  destination register of the instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_redirect  input  1  taken branch or jump resolved in EX
- ex_muldiv  input  1  EX instruction is mul/div
- ex_overflow  input  1  ALU overflow flag from EX
- pc_stop, pc_mux  output  1 each  freeze PC; select the branch target
- if_id_hold, if_id_flush  output  1 each  IF/ID buffer controls
- id_ex_hold, id_ex_flush  output  1 each  ID/EX buffer controls (flush inserts a bubble)
- ex_flush  output  1  cancel register and memory writes of the EX instruction
- ex_mem_flush  output  1  bubble into EX/MEM
- halted  output  1  core halted
- exception, exception_code  output  1, 2  overflow trap status (code 2'b01)

## Operation
- States: RUN, STALL_MD, HALT, EXCEPT. Reset enters RUN with cnt=0 and md_done=0.
- RUN priority, highest first:
  1. Overflow (if enabled): ex_overflow → ex_flush, id_ex_flush, if_id_flush and pc_stop in the same cycle. Next state is EXCEPT.
  2. Redirect: ex_redirect → pc_mux, if_id_flush and id_ex_flush for that cycle. No stall occurs.
  3. Mul/div: ex_muldiv && !md_done → pc_stop, if_id_hold, id_ex_hold and ex_mem_flush. Load cnt=MULDIV_CYCLES-1. Next state is STALL_MD.
  4. Load-use: ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)) → pc_stop, if_id_hold and id_ex_flush for exactly one cycle.
  5. HALT: id_opcode==OP_HALT → pc_stop and if_id_hold. Next state is HALT.
- A lower-priority event in the same cycle is dropped. Example: a HALT in ID under a redirect is flushed and never halts the core.
- STALL_MD:
  - Outputs: pc_stop, if_id_hold, id_ex_hold, ex_mem_flush.
  - cnt decrements each cycle. When cnt==1, go to RUN and set md_done.
  - ex_overflow, ex_redirect and ex_mem_read are ignored in this state.
- md_done: set for exactly one cycle on exit from STALL_MD. This prevents the completing mul/div from re-triggering a stall. It clears unconditionally on the next edge.
- HALT:
  - Outputs: halted, pc_stop, if_id_hold, id_ex_flush. Older instructions drain.
  - All inputs are ignored. Only reset exits this state.
- EXCEPT:
  - Outputs: exception with code 2'b01, pc_stop, if_id_flush, id_ex_flush.
  - Only reset exits this state.
- Signals not listed for a given state are 0.

## Timing
- All outputs are combinational from the current state and inputs. State, cnt and md_done update on the rising clock edge.
- While reset is asserted, every output is 0 regardless of inputs. The FSM returns to RUN immediately (asynchronous), including mid-STALL_MD.
- Load-use stall: 1 cycle.
- Mul/div stall: MULDIV_CYCLES cycles total, made up of the entry cycle plus MULDIV_CYCLES-1 cycles in STALL_MD.
- Redirect penalty: 1 cycle of flush.
- halted and exception rise one cycle after the triggering input.
- cnt width is $clog2(MULDIV_CYCLES).

## Configuration
- HAZARD_OVERFLOW_TRAP_EN defined: overflow handling is as described above, including the EXCEPT state.
- HAZARD_OVERFLOW_TRAP_EN undefined:
  - ex_overflow is ignored and EXCEPT is unreachable.
  - exception and exception_code are tied to 0.
  - ex_flush is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - the opcode constants, with OP_HALT = 4'hF;
  - the hazard state encoding;
  - EXC_OVERFLOW = 2'b01.
- Sub-module stall_counter holds the loadable down-counter: inputs load, value, en; output cnt_is_one. The FSM and output decode remain in hazard_unit.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3 → pc_stop=if_id_hold=id_ex_flush=1 for exactly 1 cycle. Repeat with ex_rd=0 → no stall.
- Mul/div with MULDIV_CYCLES=4 and ex_muldiv held for 5 cycles → stall in cycles 1-4, no stall in cycle 5, no re-trigger.
- Simultaneous events: ex_redirect=1 with a load-use hazard and id_opcode=4'hF → pc_mux=if_id_flush=id_ex_flush=1, pc_stop=0, halted stays 0.
- HALT: id_opcode=4'hF → halted=1 next cycle, pc_stop held 1 for 20 more cycles. Then reset → halted=0.
- Overflow trap with HAZARD_OVERFLOW_TRAP_EN defined: ex_overflow=1 → ex_flush=1 in the same cycle; exception=1 and code=01 from the next cycle on. With the macro undefined → all of these stay 0.
- Reset mid-stall: assert reset in STALL_MD with cnt=2 → all outputs 0 immediately. After release with ex_muldiv=0 → RUN with no stall.
